id_ex_stage: RTL



---
 rtl/dlx_pkg.sv | 61 ++++++
 rtl/hazard_detect.sv | 31 +++
 rtl/id_ex_stage.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/dlx_pkg.sv
// Shared DLX definitions: decoded control bundle, opcode and ALU operation codes.
// Used by the decode control unit and the ID/EX pipeline stage.
package dlx_pkg;

    localparam int unsigned ALU_OP_W = 6;
    localparam int unsigned OPC_W    = 6;
    localparam int unsigned CNT_W    = 32;

    // Decoded control bundle carried from ID into EX
    typedef struct packed {
        logic                reg_dst;
        logic                branch;
        logic                jump;
        logic                jr;
        logic                mem_read;
        logic                mem_to_reg;
        logic                mem_write;
        logic                alu_src;
        logic                reg_write;
        logic [ALU_OP_W-1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    // Primary opcodes
    localparam logic [OPC_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPC_W-1:0] OP_J     = 6'h02;
    localparam logic [OPC_W-1:0] OP_JAL   = 6'h03;
    localparam logic [OPC_W-1:0] OP_BEQZ  = 6'h04;
    localparam logic [OPC_W-1:0] OP_BNEZ  = 6'h05;
    localparam logic [OPC_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OPC_W-1:0] OP_ADDUI = 6'h09;
    localparam logic [OPC_W-1:0] OP_SUBI  = 6'h0a;
    localparam logic [OPC_W-1:0] OP_ANDI  = 6'h0c;
    localparam logic [OPC_W-1:0] OP_ORI   = 6'h0d;
    localparam logic [OPC_W-1:0] OP_XORI  = 6'h0e;
    localparam logic [OPC_W-1:0] OP_JR    = 6'h12;
    localparam logic [OPC_W-1:0] OP_JALR  = 6'h13;
    localparam logic [OPC_W-1:0] OP_LW    = 6'h23;
    localparam logic [OPC_W-1:0] OP_SW    = 6'h2b;

    // ALU operation codes (R-type function field encoding)
    localparam logic [ALU_OP_W-1:0] ALU_SLL  = 6'h04;
    localparam logic [ALU_OP_W-1:0] ALU_SRL  = 6'h06;
    localparam logic [ALU_OP_W-1:0] ALU_SRA  = 6'h07;
    localparam logic [ALU_OP_W-1:0] ALU_MULT = 6'h18;
    localparam logic [ALU_OP_W-1:0] ALU_ADD  = 6'h20;
    localparam logic [ALU_OP_W-1:0] ALU_ADDU = 6'h21;
    localparam logic [ALU_OP_W-1:0] ALU_SUB  = 6'h22;
    localparam logic [ALU_OP_W-1:0] ALU_SUBU = 6'h23;
    localparam logic [ALU_OP_W-1:0] ALU_AND  = 6'h24;
    localparam logic [ALU_OP_W-1:0] ALU_OR   = 6'h25;
    localparam logic [ALU_OP_W-1:0] ALU_XOR  = 6'h26;
    localparam logic [ALU_OP_W-1:0] ALU_SLT  = 6'h2a;

    // Collapse an unknown control bit to 0 so it cannot enable a state change
    function automatic logic sample_bit(input logic b);
        return (b === 1'b1);
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection between the instruction in ID and a load sitting in EX.
// Purely combinational.
module hazard_detect #(
    parameter int unsigned REG_W = 5
) (
    input  logic             ex_valid,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_dst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_jump,
    input  logic             id_alu_src,
    input  logic             id_mem_write,
    output logic             load_use
);

    logic uses_rs1;
    logic uses_rs2;
    logic rs_match;
    logic rt_match;

    // Stores read rt as write data even though the ALU takes the immediate
    always_comb begin
        uses_rs1 = ~id_jump;
        uses_rs2 = ~id_alu_src | id_mem_write;
        rs_match = uses_rs1 & (id_rs == ex_dst);
        rt_match = uses_rs2 & (id_rt == ex_dst);
        load_use = ex_valid & ex_mem_read & (ex_dst != '0) & (rs_match | rt_match);
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the DLX core with load-use bubble, flush and EX-busy hold.
// Optional performance counters (stall_cnt, bubble_cnt) under DLX_PERF_CNT_EN.
module id_ex_stage
    import dlx_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                id_reg_dst,
    input  logic                id_branch,
    input  logic                id_jump,
    input  logic                id_jr,
    input  logic                id_mem_read,
    input  logic                id_mem_to_reg,
    input  logic                id_mem_write,
    input  logic                id_alu_src,
    input  logic                id_reg_write,
    input  logic [ALU_OP_W-1:0] id_alu_op,
    input  logic                id_flush,
    input  logic                ex_busy,
    input  logic [DATA_W-1:0]   id_rs1_data,
    input  logic [DATA_W-1:0]   id_rs2_data,
    input  logic [DATA_W-1:0]   id_imm,
    input  logic [DATA_W-1:0]   id_pc4,
    input  logic [REG_W-1:0]    id_rs,
    input  logic [REG_W-1:0]    id_rt,
    input  logic [REG_W-1:0]    id_rd,

    output logic                ex_reg_dst,
    output logic                ex_branch,
    output logic                ex_jump,
    output logic                ex_jr,
    output logic                ex_mem_read,
    output logic                ex_mem_to_reg,
    output logic                ex_mem_write,
    output logic                ex_alu_src,
    output logic                ex_reg_write,
    output logic [ALU_OP_W-1:0] ex_alu_op,
    output logic [DATA_W-1:0]   ex_rs1_data,
    output logic [DATA_W-1:0]   ex_rs2_data,
    output logic [DATA_W-1:0]   ex_imm,
    output logic [DATA_W-1:0]   ex_pc4,
    output logic [REG_W-1:0]    ex_rs,
    output logic [REG_W-1:0]    ex_rt,
    output logic [REG_W-1:0]    ex_dst,
    output logic                ex_valid,
    output logic                pc_write,
    output logic                ifid_write
`ifdef DLX_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]    stall_cnt,
    output logic [CNT_W-1:0]    bubble_cnt
`endif
);

    ctrl_t            id_ctrl;
    ctrl_t            ex_ctrl;
    logic [REG_W-1:0] id_dst;
    logic             load_use;
    logic             stall;
    logic             bubble;

    // Pack decode controls; write enables are scrubbed of unknowns
    always_comb begin
        id_ctrl            = CTRL_NOP;
        id_ctrl.reg_dst    = id_reg_dst;
        id_ctrl.branch     = id_branch;
        id_ctrl.jump       = id_jump;
        id_ctrl.jr         = id_jr;
        id_ctrl.mem_read   = id_mem_read;
        id_ctrl.mem_to_reg = id_mem_to_reg;
        id_ctrl.mem_write  = sample_bit(id_mem_write);
        id_ctrl.alu_src    = id_alu_src;
        id_ctrl.reg_write  = sample_bit(id_reg_write);
        id_ctrl.alu_op     = id_alu_op;
        id_dst             = id_reg_dst ? id_rd : id_rt;
    end

    hazard_detect #(
        .REG_W(REG_W)
    ) u_hazard_detect (
        .ex_valid     (ex_valid),
        .ex_mem_read  (ex_ctrl.mem_read),
        .ex_dst       (ex_dst),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_jump      (id_jump),
        .id_alu_src   (id_alu_src),
        .id_mem_write (id_ctrl.mem_write),
        .load_use     (load_use)
    );

    // A flush kills the dependent instruction, so it overrides the hazard stall
    assign stall      = ex_busy | (load_use & ~id_flush);
    assign bubble     = id_flush | (~ex_busy & load_use);
    assign pc_write   = ~stall;
    assign ifid_write = ~stall;

    // Pipeline register: reset > flush > busy hold > load-use bubble > capture
    always_ff @(posedge clk) begin
        if (reset || bubble) begin
            ex_ctrl     <= CTRL_NOP;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_pc4      <= '0;
            ex_rs       <= '0;
            ex_rt       <= '0;
            ex_dst      <= '0;
            ex_valid    <= 1'b0;
        end else if (!ex_busy) begin
            ex_ctrl     <= id_ctrl;
            ex_rs1_data <= id_rs1_data;
            ex_rs2_data <= id_rs2_data;
            ex_imm      <= id_imm;
            ex_pc4      <= id_pc4;
            ex_rs       <= id_rs;
            ex_rt       <= id_rt;
            ex_dst      <= id_dst;
            ex_valid    <= 1'b1;
        end
    end

    assign ex_reg_dst    = ex_ctrl.reg_dst;
    assign ex_branch     = ex_ctrl.branch;
    assign ex_jump       = ex_ctrl.jump;
    assign ex_jr         = ex_ctrl.jr;
    assign ex_mem_read   = ex_ctrl.mem_read;
    assign ex_mem_to_reg = ex_ctrl.mem_to_reg;
    assign ex_mem_write  = ex_ctrl.mem_write;
    assign ex_alu_src    = ex_ctrl.alu_src;
    assign ex_reg_write  = ex_ctrl.reg_write;
    assign ex_alu_op     = ex_ctrl.alu_op;

`ifdef DLX_PERF_CNT_EN
    // Free-running event counters, wrapping naturally
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (stall) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (bubble) begin
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule
